// File: rtl/ext_pwr_seq.sv
// ext_pwr_seq: one-at-a-time power sequencer for external switched domains.
// Define EXT_PWR_SEQ_TIMEOUT_EN to enable the switch-acknowledge timeout.
module ext_pwr_seq #(
  parameter int NUM_DOMAINS = 2,
  parameter int CLKGATE_DLY = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_DOMAINS-1:0] target_on_i,
  input  logic [NUM_DOMAINS-1:0] err_clr_i,
  input  logic [NUM_DOMAINS-1:0] switch_ack_ni,
  output logic [NUM_DOMAINS-1:0] switch_no,
  output logic [NUM_DOMAINS-1:0] iso_no,
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic [NUM_DOMAINS-1:0] clkgate_en_no,
  output logic [NUM_DOMAINS-1:0] state_on_o,
  output logic [NUM_DOMAINS-1:0] done_o,
  output logic [NUM_DOMAINS-1:0] err_o,
  output logic                   busy_o
);

  localparam int N    = NUM_DOMAINS;
  localparam int CMAX = (CLKGATE_DLY > ACK_TIMEOUT) ?
                        CLKGATE_DLY : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] GATE_LAST =
    CW'(CLKGATE_DLY - 1);
  // UP_RST takes one of the CLKGATE_DLY cycles, UP_GATE the rest
  localparam logic [CW-1:0] UPG_LAST =
    CW'((CLKGATE_DLY > 1) ? CLKGATE_DLY - 2 : 0);

  typedef enum logic [2:0] {
    IDLE,
    DN_GATE,
    DN_ISO,
    DN_SW,
    UP_SW,
    UP_RST,
    UP_GATE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;

  logic [N-1:0]  switch_q, switch_d;
  logic [N-1:0]  iso_q, iso_d;
  logic [N-1:0]  drst_q, drst_d;
  logic [N-1:0]  gate_q, gate_d;
  logic [N-1:0]  on_q, on_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  err_q, err_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  req;
  logic [SW-1:0] pick;
  logic          pick_vld;
  logic          ack_hit;
  logic          tmo_hit;
  logic [N-1:0]  err_keep;

  always_comb begin
    req      = (target_on_i ^ on_q) & ~err_q;
    pick_vld = |req;
    pick     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) pick = SW'(i);
    end
  end

  assign ack_hit = (state_q == DN_SW) ?
                   switch_ack_ni[sel_q] :
                   ~switch_ack_ni[sel_q];

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST =
    CW'(ACK_TIMEOUT - 1);

  assign tmo_hit  = ((state_q == DN_SW) ||
                     (state_q == UP_SW)) &&
                    (cnt_q == TMO_LAST) && !ack_hit;
  assign err_keep = err_q & ~err_clr_i;
`else
  logic unused_err_clr;

  assign unused_err_clr = ^err_clr_i;
  assign tmo_hit        = 1'b0;
  assign err_keep       = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      switch_q <= '0;
      iso_q    <= '1;
      drst_q   <= '1;
      gate_q   <= '1;
      on_q     <= '1;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      switch_q <= switch_d;
      iso_q    <= iso_d;
      drst_q   <= drst_d;
      gate_q   <= gate_d;
      on_q     <= on_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick;
          state_d = on_q[pick] ? DN_GATE : UP_SW;
        end
      end
      DN_GATE: begin
        if (cnt_q == GATE_LAST) state_d = DN_ISO;
      end
      DN_ISO: begin
        state_d = DN_SW;
      end
      DN_SW: begin
        if (ack_hit || tmo_hit) state_d = IDLE;
      end
      UP_SW: begin
        if (ack_hit)      state_d = UP_RST;
        else if (tmo_hit) state_d = IDLE;
      end
      UP_RST: begin
        state_d = (CLKGATE_DLY > 1) ? UP_GATE : IDLE;
      end
      UP_GATE: begin
        if (cnt_q == UPG_LAST) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs change on the same edge as the state transition that owns them
  always_comb begin
    switch_d = switch_q;
    iso_d    = iso_q;
    drst_d   = drst_q;
    gate_d   = gate_q;
    on_d     = on_q;
    done_d   = '0;
    err_d    = err_keep;
    busy_d   = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          if (on_q[pick]) gate_d[pick]   = 1'b0;
          else            switch_d[pick] = 1'b0;
        end
      end
      DN_GATE: begin
        if (state_d == DN_ISO) begin
          iso_d[sel_q]  = 1'b0;
          drst_d[sel_q] = 1'b0;
        end
      end
      DN_ISO: begin
        switch_d[sel_q] = 1'b1;
      end
      DN_SW: begin
        if (ack_hit || tmo_hit) begin
          on_d[sel_q]   = 1'b0;
          done_d[sel_q] = 1'b1;
        end
        if (tmo_hit) err_d[sel_q] = 1'b1;
      end
      UP_SW: begin
        if (ack_hit) begin
          iso_d[sel_q]  = 1'b1;
          drst_d[sel_q] = 1'b1;
        end else if (tmo_hit) begin
          switch_d[sel_q] = 1'b1;
          done_d[sel_q]   = 1'b1;
          err_d[sel_q]    = 1'b1;
        end
      end
      UP_RST, UP_GATE: begin
        if (state_d == IDLE) begin
          gate_d[sel_q] = 1'b1;
          on_d[sel_q]   = 1'b1;
          done_d[sel_q] = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign switch_no     = switch_q;
  assign iso_no        = iso_q;
  assign rst_no        = drst_q;
  assign clkgate_en_no = gate_q;
  assign state_on_o    = on_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ext_pwr_seq.sv
// tb_ext_pwr_seq: directed bench for ext_pwr_seq with a timeline model.
// Timeout scenario runs only when EXT_PWR_SEQ_TIMEOUT_EN is defined.
module tb_ext_pwr_seq;

  localparam int DLY = 4;
  localparam int TMO = 8;
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] target = 2'b11;
  logic [1:0] clr = 2'b00;
  logic [1:0] ack;
  logic [1:0] switch_no, iso_no, rst_no, clkgate_en_no;
  logic [1:0] state_on_o, done_o, err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  ext_pwr_seq #(
    .NUM_DOMAINS(2),
    .CLKGATE_DLY(DLY),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .target_on_i(target),
    .err_clr_i(clr),
    .switch_ack_ni(ack),
    .switch_no(switch_no),
    .iso_no(iso_no),
    .rst_no(rst_no),
    .clkgate_en_no(clkgate_en_no),
    .state_on_o(state_on_o),
    .done_o(done_o),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // External switch: acknowledge follows switch_no three cycles later
  logic [1:0] d1 = '0, d2 = '0, d3 = '0;
  logic [1:0] force_hi = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      d1 <= switch_no; d2 <= d1; d3 <= d2;
    end
  end
  assign ack = d3 | force_hi;

  // Timeline model: outputs derived from edge distance to sequence start/ack
  int ecnt = 0, s_e = 0, a_e = -1, age = 0, dom = 0;
  bit act = 1'b0, up = 1'b0;
  logic [1:0] m_sw = '0, m_iso = '1, m_rst = '1, m_gate = '1;
  logic [1:0] m_on = '1, m_done = '0, m_err = '0;
  logic [1:0] m_set, m_pend;
  logic       m_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sw = '0; m_iso = '1; m_rst = '1; m_gate = '1;
      m_on = '1; m_done = '0; m_err = '0; m_busy = 1'b0;
      act = 1'b0;
    end else begin
      ecnt++;
      m_done = '0;
      m_set  = '0;
      m_pend = (target ^ m_on) & ~m_err;
      if (act) begin
        age = ecnt - s_e;
        if (!up) begin
          if (age == DLY) begin
            m_iso[dom] = 1'b0; m_rst[dom] = 1'b0;
          end else if (age == DLY + 1) begin
            m_sw[dom] = 1'b1;
          end else if (age >= DLY + 2) begin
            if (ack[dom]) begin
              m_on[dom] = 1'b0; m_done[dom] = 1'b1; act = 1'b0;
            end else if (TMO_EN && age == DLY + 1 + TMO) begin
              m_on[dom] = 1'b0; m_done[dom] = 1'b1;
              m_set[dom] = 1'b1; act = 1'b0;
            end
          end
        end else if (a_e < 0) begin
          if (!ack[dom]) begin
            a_e = ecnt; m_iso[dom] = 1'b1; m_rst[dom] = 1'b1;
          end else if (TMO_EN && age == TMO) begin
            m_sw[dom] = 1'b1; m_done[dom] = 1'b1;
            m_set[dom] = 1'b1; act = 1'b0;
          end
        end else if (ecnt - a_e == DLY) begin
          m_gate[dom] = 1'b1; m_on[dom] = 1'b1;
          m_done[dom] = 1'b1; act = 1'b0;
        end
      end else if (m_pend != 2'b00) begin
        for (int i = 1; i >= 0; i--) if (m_pend[i]) dom = i;
        up  = target[dom];
        s_e = ecnt; a_e = -1; act = 1'b1;
        if (up) m_sw[dom] = 1'b0;
        else    m_gate[dom] = 1'b0;
      end
      if (TMO_EN) m_err = (m_err & ~clr) | m_set;
      else        m_err = '0;
      m_busy = act;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp switch_no", 16'(switch_no), 16'(m_sw));
      chk("cmp iso_no", 16'(iso_no), 16'(m_iso));
      chk("cmp rst_no", 16'(rst_no), 16'(m_rst));
      chk("cmp clkgate_en_no", 16'(clkgate_en_no), 16'(m_gate));
      chk("cmp state_on_o", 16'(state_on_o), 16'(m_on));
      chk("cmp done_o", 16'(done_o), 16'(m_done));
      chk("cmp err_o", 16'(err_o), 16'(m_err));
      chk("cmp busy_o", 16'(busy_o), 16'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int lim);
    int n = 0;
    while (done_o[d] !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (done_o[d] !== 1'b1) begin
      errors++;
      $display("FAIL wait_done[%0d] got no done exp within %0d", d, lim);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp end by 100000");
    $fatal(1);
  end

  initial begin
    // Reset, all domains requested on: nothing happens
    repeat (3) tick();
    chk_on = 1'b1;
    rst = 1'b0;
    repeat (4) tick();
    chk("rst busy", 16'(busy_o), 16'h0);
    chk("rst switch", 16'(switch_no), 16'h0);
    chk("rst iso", 16'(iso_no), 16'h3);
    chk("rst gate", 16'(clkgate_en_no), 16'h3);
    chk("rst on", 16'(state_on_o), 16'h3);

    // Domain 0 power-down timing
    target = 2'b10;
    tick();
    chk("dn gate T+1", 16'(clkgate_en_no), 16'h2);
    chk("dn busy T+1", 16'(busy_o), 16'h1);
    repeat (3) tick();
    chk("dn iso T+4", 16'(iso_no), 16'h3);
    tick();
    chk("dn iso T+5", 16'(iso_no), 16'h2);
    chk("dn rst T+5", 16'(rst_no), 16'h2);
    chk("dn sw T+5", 16'(switch_no), 16'h0);
    tick();
    chk("dn sw T+6", 16'(switch_no), 16'h1);
    repeat (3) tick();
    chk("dn on T+9", 16'(state_on_o), 16'h3);
    tick();
    chk("dn done T+10", 16'(done_o), 16'h1);
    chk("dn on T+10", 16'(state_on_o), 16'h2);
    chk("dn idle T+10", 16'(busy_o), 16'h0);

    // Domain 0 power-up timing
    tick();
    target = 2'b11;
    tick();
    chk("up sw T+1", 16'(switch_no), 16'h0);
    repeat (3) tick();
    chk("up iso T+4", 16'(iso_no), 16'h2);
    tick();
    chk("up iso T+5", 16'(iso_no), 16'h3);
    chk("up rst T+5", 16'(rst_no), 16'h3);
    chk("up gate T+5", 16'(clkgate_en_no), 16'h2);
    repeat (3) tick();
    chk("up gate T+8", 16'(clkgate_en_no), 16'h2);
    tick();
    chk("up gate T+9", 16'(clkgate_en_no), 16'h3);
    chk("up done T+9", 16'(done_o), 16'h1);
    chk("up on T+9", 16'(state_on_o), 16'h3);

    // Both off together: domain 0 first, then domain 1 after one IDLE
    tick();
    target = 2'b00;
    repeat (10) tick();
    chk("b2b done0", 16'(done_o), 16'h1);
    chk("b2b idle", 16'(busy_o), 16'h0);
    chk("b2b gate1 held", 16'(clkgate_en_no), 16'h2);
    tick();
    chk("b2b gate1 T+11", 16'(clkgate_en_no), 16'h0);
    chk("b2b busy T+11", 16'(busy_o), 16'h1);
    repeat (9) tick();
    chk("b2b done1", 16'(done_o), 16'h2);
    chk("b2b on", 16'(state_on_o), 16'h0);

    // Both back on
    tick();
    target = 2'b11;
    wait_done(0, 30);
    tick();
    wait_done(1, 30);
    repeat (2) tick();

    // Target flips back during DN_SW: down completes, up follows
    target = 2'b10;
    repeat (6) tick();
    chk("flip sw T+6", 16'(switch_no), 16'h1);
    target = 2'b11;
    repeat (4) tick();
    chk("flip done T+10", 16'(done_o), 16'h1);
    chk("flip on T+10", 16'(state_on_o), 16'h2);
    tick();
    chk("flip sw T+11", 16'(switch_no), 16'h0);
    chk("flip busy T+11", 16'(busy_o), 16'h1);
    repeat (8) tick();
    chk("flip done T+19", 16'(done_o), 16'h1);
    chk("flip on T+19", 16'(state_on_o), 16'h3);

    // Asynchronous reset during DN_GATE
    tick();
    target = 2'b10;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst gate", 16'(clkgate_en_no), 16'h3);
    chk("arst iso", 16'(iso_no), 16'h3);
    chk("arst rst", 16'(rst_no), 16'h3);
    chk("arst sw", 16'(switch_no), 16'h0);
    chk("arst busy", 16'(busy_o), 16'h0);
    target = 2'b11;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("arst after", 16'(busy_o), 16'h0);

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
    // Domain 1 up with ack stuck high; clear in the timeout cycle loses
    target = 2'b01;
    wait_done(1, 30);
    repeat (2) tick();
    force_hi = 2'b10;
    target = 2'b11;
    tick();
    chk("tmo sw T+1", 16'(switch_no), 16'h0);
    repeat (7) tick();
    clr = 2'b10;
    tick();
    clr = 2'b00;
    chk("tmo err", 16'(err_o), 16'h2);
    chk("tmo done", 16'(done_o), 16'h2);
    chk("tmo sw", 16'(switch_no), 16'h2);
    chk("tmo on", 16'(state_on_o), 16'h1);
    chk("tmo iso", 16'(iso_no), 16'h1);
    repeat (5) tick();
    chk("tmo no resel", 16'(busy_o), 16'h0);
    clr = 2'b10;
    tick();
    clr = 2'b00;
    chk("clr err", 16'(err_o), 16'h0);
    chk("clr idle", 16'(busy_o), 16'h0);
    tick();
    chk("clr resel", 16'(busy_o), 16'h1);
    chk("clr sw", 16'(switch_no), 16'h0);
    force_hi = 2'b00;
    wait_done(1, 40);
    chk("clr up on", 16'(state_on_o), 16'h3);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_pwr_seq.md
EXT_PWR_SEQ -- requirements
Module: ext_pwr_seq

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2, number of external power domains (legal 1..16).
REQ-002 SHALL have parameter CLKGATE_DLY, default 4, cycles between clock-gate and iso/reset edges (legal >=1).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 64, maximum cycles waiting for switch acknowledge (legal >=1).
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  system clock.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 target_on_i  in  NUM_DOMAINS  requested power state per domain (1 = on).
REQ-008 err_clr_i  in  NUM_DOMAINS  per-domain error clear pulse.
REQ-009 switch_ack_ni  in  NUM_DOMAINS  power-switch acknowledge, active-low (0 = powered).
REQ-010 switch_no  out  NUM_DOMAINS  power-switch control, active-low (0 = powered).
REQ-011 iso_no  out  NUM_DOMAINS  isolation, active-low (0 = isolated).
REQ-012 rst_no  out  NUM_DOMAINS  domain reset, active-low.
REQ-013 clkgate_en_no  out  NUM_DOMAINS  clock enable, active-low gating (0 = clock gated).
REQ-014 state_on_o  out  NUM_DOMAINS  current committed state per domain.
REQ-015 done_o  out  NUM_DOMAINS  one-cycle pulse on sequence completion (success or error).
REQ-016 err_o  out  NUM_DOMAINS  sticky acknowledge-timeout flag.
REQ-017 busy_o  out  1  high whenever FSM not in IDLE.

Function
REQ-018 All outputs SHALL be registered; one sequencer serves one domain at a time.
REQ-019 In IDLE, SHALL select lowest index d with target_on_i[d] != state_on_o[d] and err_o[d]==0; lock d until return to IDLE; target changes mid-sequence ignored until then.
REQ-020 States SHALL be IDLE, DN_GATE, DN_ISO, DN_SW, UP_SW, UP_RST, UP_GATE.
REQ-021 Power-down: clkgate_en_no[d] falls 1 cycle after mismatch sampled (enter DN_GATE); iso_no[d] and rst_no[d] fall CLKGATE_DLY cycles later (DN_ISO, 1 cycle); switch_no[d] rises next cycle (DN_SW).
REQ-022 DN_SW: when switch_ack_ni[d]==1 sampled, next cycle state_on_o[d]=0, done_o[d] pulses, FSM to IDLE.
REQ-023 Power-up: switch_no[d] falls 1 cycle after mismatch sampled (UP_SW); when switch_ack_ni[d]==0 sampled, next cycle rst_no[d], iso_no[d] rise (UP_RST); clkgate_en_no[d] rises CLKGATE_DLY cycles later together with state_on_o[d]=1 and done_o[d] pulse, FSM to IDLE.
REQ-024 Single counter, width $clog2(max(CLKGATE_DLY,ACK_TIMEOUT)+1), cleared on every state entry, saturating.
REQ-025 Back-to-back: a new selection SHALL be evaluated in the IDLE cycle following done_o; minimum one IDLE cycle between sequences.
REQ-026 err_o[d] set and err_clr_i[d] in same cycle: set wins.
REQ-027 Non-selected domains' outputs SHALL hold their values throughout.

Reset
REQ-028 rst_i asserted (any time, including mid-sequence) SHALL immediately force: switch_no=0, iso_no=1, rst_no=1, clkgate_en_no=1, state_on_o=all 1, done_o=0, err_o=0, busy_o=0, FSM IDLE, counter 0.
REQ-029 First selection SHALL occur on the first clk_i edge after rst_i deasserts.

Configuration
REQ-030 Macro EXT_PWR_SEQ_TIMEOUT_EN defined: after ACK_TIMEOUT cycles in DN_SW/UP_SW without matching ack, SHALL set err_o[d], pulse done_o[d], go IDLE; DN timeout: state_on_o[d]=0, outputs held off; UP timeout: switch_no[d] returns to 1, state_on_o[d] stays 0, iso/rst/clkgate stay asserted.
REQ-031 Macro undefined: SHALL wait for acknowledge indefinitely; err_o tied 0; err_clr_i ignored.

Verification (NUM_DOMAINS=2, CLKGATE_DLY=4, ACK_TIMEOUT=8)
REQ-032 Reset release, target_on_i=2'b11 -> no activity, busy_o=0, all outputs at reset values.
REQ-033 target_on_i[0] 1->0, ack follows switch_no after 3 cycles -> clkgate_en_no[0] falls T+1, iso/rst fall T+5, switch_no rises T+6, state_on_o[0]=0 and done_o[0] at ack-sample+1.
REQ-034 Both domains request off in same cycle -> domain 0 fully sequenced first, domain 1 starts after one IDLE cycle.
REQ-035 Power-up of domain 1, ack held 1 (TIMEOUT_EN defined) -> after 8 cycles err_o[1]=1, switch_no[1]=1, state_on_o[1]=0; domain 1 not reselected until err_clr_i[1].
REQ-036 rst_i pulsed during DN_GATE of domain 0 -> all outputs to reset values asynchronously, busy_o=0.
REQ-037 Toggle target_on_i[0] back to 1 during DN_SW -> power-down completes, then power-up sequence starts automatically.
